ibex_instr_mem_responder: RTL

IBEX_INSTR_MEM_RESPONDER -- requirements
Module: ibex_instr_mem_responder

---
 rtl/ibex_instr_mem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/ibex_instr_mem_responder.sv
// ibex_instr_mem_responder: in-order instruction fetch responder over a shared SRAM port with out-of-range error responses.
module ibex_instr_mem_responder #(
    parameter logic                 ResetAll       = 1'b0,
    parameter logic        [31:0]   MemBase        = 32'h0000_0000,
    parameter logic        [31:0]   MemSizeBytes   = 32'h0001_0000,
    parameter int unsigned          MaxOutstanding = 2,
    localparam int unsigned         AddrW          = $clog2(MemSizeBytes) - 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    output logic             instr_gnt_o,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    output logic             sram_req_o,
    input  logic             sram_gnt_i,
    output logic [AddrW-1:0] sram_addr_o,
    input  logic             sram_rvalid_i,
    input  logic [31:0]      sram_rdata_i,
    output logic             busy_o
);
    localparam int unsigned Depth = MaxOutstanding;
    localparam int unsigned PtrW  = Depth > 1 ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic [CntW-1:0]             count_q, count_d;
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, fill_idx;
    logic [Depth-1:0]            filled_q, filled_d, err_q, err_d;
    logic [Depth-1:0][31:0]      rdata_q, rdata_d;
    logic [31:0]                 offset;
    logic                        in_range, space, head_filled, bypass, fill_hit;

    function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    assign offset         = instr_addr_i - MemBase;
    assign in_range       = offset < MemSizeBytes;
    assign space          = rst_ni & (count_q < CntW'(Depth));
    assign sram_req_o     = instr_req_i & in_range & space;
    assign sram_addr_o    = offset[AddrW+1:2];
    assign instr_gnt_o    = instr_req_i & space & (in_range ? sram_gnt_i : 1'b1);
    assign head_filled    = filled_q[rd_ptr_q];
    assign bypass         = (count_q != '0) & ~head_filled & sram_rvalid_i;
    assign instr_rvalid_o = head_filled | bypass;
    assign instr_rdata_o  = bypass ? sram_rdata_i : head_filled ? rdata_q[rd_ptr_q] : 32'h0;
    assign instr_err_o    = head_filled & err_q[rd_ptr_q];
    assign busy_o         = count_q != '0;

    // Oldest unfilled entry: scan youngest to oldest so the oldest match wins.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        for (int i = int'(Depth) - 1; i >= 0; i--) begin
            if (i < int'(count_q) && !filled_q[(int'(rd_ptr_q) + i) % int'(Depth)]) begin
                fill_hit = 1'b1;
                fill_idx = PtrW'((int'(rd_ptr_q) + i) % int'(Depth));
            end
        end
    end

    always_comb begin
        filled_d = filled_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rd_ptr_d = instr_rvalid_o ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = instr_gnt_o ? nxt(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CntW'(instr_gnt_o) - CntW'(instr_rvalid_o);
        if (sram_rvalid_i && fill_hit && !bypass) begin
            filled_d[fill_idx] = 1'b1;
            rdata_d[fill_idx]  = sram_rdata_i;
        end
        if (instr_rvalid_o) begin
            filled_d[rd_ptr_q] = 1'b0;
            err_d[rd_ptr_q]    = 1'b0;
        end
        if (instr_gnt_o) begin
            filled_d[wr_ptr_q] = ~in_range;
            err_d[wr_ptr_q]    = ~in_range;
            if (!in_range) rdata_d[wr_ptr_q] = 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            filled_q <= '0;
            err_q    <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            filled_q <= filled_d;
            err_q    <= err_d;
        end
    end

    if (ResetAll) begin : g_rdata_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) rdata_q <= '0;
            else rdata_q <= rdata_d;
        end
    end else begin : g_rdata_nrst
        always_ff @(posedge clk_i) rdata_q <= rdata_d;
    end

    a_sram_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        sram_rvalid_i |-> fill_hit);
endmodule
